// File: rtl/gpio_input_debouncer.sv
// gpio_input_debouncer: per-bit 2-flop synchroniser, stability counter, debounced level and edge pulses
module gpio_input_debouncer #(
  parameter int GPIO_WIDTH = 3,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter logic [GPIO_WIDTH-1:0] RESET_VALUE = {GPIO_WIDTH{1'b0}}
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic [GPIO_WIDTH-1:0] gpio_raw,
  output logic [GPIO_WIDTH-1:0] gpio_debounced,
  output logic [GPIO_WIDTH-1:0] gpio_rise,
  output logic [GPIO_WIDTH-1:0] gpio_fall,
  output logic                  gpio_any_edge
);
  localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [GPIO_WIDTH-1:0] r_sync1, r_sync2, r_deb, r_rise, r_fall, w_accept;
  logic                  r_any;
  logic [CW-1:0]         r_cnt [GPIO_WIDTH];
  // a bit is accepted on the edge that completes its run of mismatching samples
  always_comb begin
    w_accept = '0;
    for (int i = 0; i < GPIO_WIDTH; i++)
      w_accept[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == LAST);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sync1 <= RESET_VALUE;
      r_sync2 <= RESET_VALUE;
      r_deb   <= RESET_VALUE;
      r_rise  <= '0;
      r_fall  <= '0;
      r_any   <= 1'b0;
      for (int i = 0; i < GPIO_WIDTH; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= gpio_raw;
      r_sync2 <= r_sync1;
      r_deb   <= r_deb ^ w_accept;
      r_rise  <= w_accept & r_sync2;
      r_fall  <= w_accept & ~r_sync2;
      r_any   <= |w_accept;
      for (int i = 0; i < GPIO_WIDTH; i++)
        r_cnt[i] <= (r_sync2[i] == r_deb[i] || w_accept[i]) ? '0 : r_cnt[i] + 1'b1;
    end
  end
  assign gpio_debounced = r_deb;
  assign gpio_rise      = r_rise;
  assign gpio_fall      = r_fall;
  assign gpio_any_edge  = r_any;
endmodule

// File: tb/tb_gpio_input_debouncer.sv
// tb_gpio_input_debouncer: three debouncer configurations driven in parallel against a run-length reference model
module tb_gpio_input_debouncer;
  localparam int D [3] = '{4, 1, 4};
  localparam logic [2:0] RV [3] = '{3'b000, 3'b000, 3'b111};
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] gpio_raw = 3'b000;
  logic [2:0] o_deb [3];
  logic [2:0] o_rise [3];
  logic [2:0] o_fall [3];
  logic       o_any [3];
  int n_checks = 0;
  int n_errors = 0;
  logic [2:0] m_pipe [3][2];
  logic [2:0] m_deb [3];
  logic [2:0] m_rise [3];
  logic [2:0] m_fall [3];
  logic       m_any [3];
  int         m_run [3][3];
  always #5 clock = ~clock;
  for (genvar k = 0; k < 3; k++) begin : g_dut
    gpio_input_debouncer #(
      .GPIO_WIDTH(3), .DEBOUNCE_CYCLES(D[k]), .RESET_VALUE(RV[k])
    ) u_dut (
      .clock(clock), .reset(reset), .gpio_raw(gpio_raw),
      .gpio_debounced(o_deb[k]), .gpio_rise(o_rise[k]),
      .gpio_fall(o_fall[k]), .gpio_any_edge(o_any[k])
    );
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_pipe[k][0] = RV[k];
      m_pipe[k][1] = RV[k];
      m_deb[k] = RV[k];
      m_rise[k] = '0;
      m_fall[k] = '0;
      m_any[k] = 1'b0;
      for (int i = 0; i < 3; i++) m_run[k][i] = 0;
    end
  endtask
  // a bit flips once it has disagreed with its accepted level for D consecutive synchronised samples
  task automatic model_edge();
    if (reset) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 3; k++) begin
      m_rise[k] = '0;
      m_fall[k] = '0;
      for (int i = 0; i < 3; i++) begin
        if (m_pipe[k][1][i] != m_deb[k][i]) begin
          m_run[k][i] = m_run[k][i] + 1;
          if (m_run[k][i] == D[k]) begin
            m_deb[k][i] = m_pipe[k][1][i];
            if (m_deb[k][i]) m_rise[k][i] = 1'b1;
            else m_fall[k][i] = 1'b1;
            m_run[k][i] = 0;
          end
        end else m_run[k][i] = 0;
      end
      m_any[k] = |(m_rise[k] | m_fall[k]);
      m_pipe[k][1] = m_pipe[k][0];
      m_pipe[k][0] = gpio_raw;
    end
  endtask
  task automatic compare_all();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("deb%0d", k), 32'(o_deb[k]), 32'(m_deb[k]));
      check($sformatf("rise%0d", k), 32'(o_rise[k]), 32'(m_rise[k]));
      check($sformatf("fall%0d", k), 32'(o_fall[k]), 32'(m_fall[k]));
      check($sformatf("any%0d", k), 32'(o_any[k]), 32'(m_any[k]));
    end
  endtask
  task automatic step(input logic [2:0] raw, input logic rst);
    @(negedge clock);
    gpio_raw = raw;
    reset = rst;
    @(posedge clock);
    #1;
    model_edge();
    compare_all();
  endtask
  task automatic hold(input logic [2:0] raw, input int n);
    for (int j = 0; j < n; j++) step(raw, 1'b0);
  endtask
  task automatic async_reset(input logic [2:0] raw_after);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    step(gpio_raw, 1'b1);
    step(gpio_raw, 1'b1);
    step(raw_after, 1'b0);
  endtask
  initial begin
    model_reset();
    #1 reset = 1'b1;
    #1 compare_all();
    step(3'b000, 1'b1);
    step(3'b000, 1'b0);
    hold(3'b000, 6);
    // clean step on bit0: accepted on the fifth edge after the one that samples it
    step(3'b001, 1'b0);
    hold(3'b001, 4);
    check("step_pre_deb0", 32'(o_deb[0]), 32'h0);
    step(3'b001, 1'b0);
    check("step_deb0", 32'(o_deb[0]), 32'h1);
    check("step_rise0", 32'(o_rise[0]), 32'h1);
    check("step_any0", 32'(o_any[0]), 32'h1);
    step(3'b001, 1'b0);
    check("step_rise0_once", 32'(o_rise[0]), 32'h0);
    hold(3'b011, 8);
    // bit1 glitches low for three samples, too short to be accepted with D=4
    for (int r = 0; r < 4; r++) begin
      hold(3'b001, 3);
      hold(3'b011, 3);
    end
    check("glitch_deb1", 32'(o_deb[0][1]), 32'h1);
    hold(3'b111, 8);
    step(3'b010, 1'b0);
    hold(3'b010, 4);
    step(3'b010, 1'b0);
    check("sim_fall", 32'(o_fall[0]), 32'h5);
    check("sim_deb", 32'(o_deb[0]), 32'h2);
    hold(3'b000, 8);
    hold(3'b001, 4);
    async_reset(3'b001);
    hold(3'b001, 4);
    check("rel_no_rise_yet", 32'(o_rise[0]), 32'h0);
    step(3'b001, 1'b0);
    check("rel_rise0", 32'(o_rise[0]), 32'h1);
    hold(3'b000, 8);
    hold(3'b100, 1);
    hold(3'b000, 6);
    for (int s = 0; s < 300; s++) begin
      if ($urandom_range(0, 39) == 0) async_reset(3'($urandom));
      else hold(3'($urandom), $urandom_range(1, 7));
    end
    async_reset(3'b111);
    hold(3'b111, 20);
    check("rv111_deb", 32'(o_deb[2]), 32'h7);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
